hemaia_reset_sequencer: RTL
===========================

HEMAIA_RESET_SEQUENCER -- requirements
Module: hemaia_reset_sequencer

Interface
REQ-001 SHALL have parameter NumReset, default 4, number of reset channels (legal range 1..32).
REQ-002 SHALL have parameter HoldCycles, default 8, cycles a channel's local reset stays asserted (legal range >=1).
REQ-003 SHALL have parameter GapCycles, default 2, cycles between consecutive channel releases (legal range >=1).
REQ-004 SHALL have port clk_i, input, 1, the single clock; one clock, reset is synchronous and active-high.
REQ-005 SHALL have port rst_i, input, 1, synchronous active-high reset.
REQ-006 SHALL have port soft_rst_req_i, input, NumReset, per-channel level soft-reset request.
REQ-007 SHALL have port soft_rst_ack_o, output, NumReset, per-channel one-cycle completion pulse.
REQ-008 SHALL have port local_rst_no, output, NumReset, active-low local resets, one per channel, feeding the per-channel reset synchronisers.
REQ-009 SHALL have port busy_o, output, 1, high while any sequence or soft reset is in progress.
REQ-010 SHALL have port done_o, output, 1, high once the boot sequence has completed.

Function
REQ-011 SHALL implement FSM states INIT_HOLD, RELEASE_GAP, RUN, SOFT_HOLD and SOFT_GAP.
REQ-012 SHALL hold all local_rst_no low for HoldCycles cycles in INIT_HOLD, starting at the first edge with rst_i low, then release channel 0.
REQ-013 SHALL release channels in ascending index order, channel k+1 exactly GapCycles cycles after channel k (state RELEASE_GAP).
REQ-014 SHALL raise done_o and enter RUN GapCycles cycles after the last channel release; done_o SHALL then stay high until rst_i.
REQ-015 SHALL register all outputs, with no combinational path from any input to any output.
REQ-016 SHALL, in RUN, select the lowest-index eligible soft_rst_req_i bit; selection takes one cycle into SOFT_HOLD.
REQ-017 SHALL, in SOFT_HOLD, drive only the selected channel's local_rst_no low for HoldCycles cycles; all other channels SHALL stay high.
REQ-018 SHALL, after SOFT_HOLD, release the channel and wait GapCycles cycles in SOFT_GAP, then pulse soft_rst_ack_o for that channel for one cycle and return to RUN.
REQ-019 SHALL mark a channel as served when its ack pulses; a served channel SHALL become eligible again only after its soft_rst_req_i has been sampled low for at least one cycle.
REQ-020 SHALL keep soft requests raised during INIT_HOLD or RELEASE_GAP pending and serve them after done_o rises.
REQ-021 SHALL ignore changes to soft_rst_req_i on the channel being served until its ack has been issued (no abort).
REQ-022 SHALL serve simultaneous requests one at a time, lowest index first; the others stay pending.
REQ-023 SHALL drive busy_o high in every state except RUN.
REQ-024 SHALL size the timer as $clog2(max(HoldCycles,GapCycles)+1) bits, a down-counter with no wrap-around.

Reset
REQ-025 SHALL, while rst_i is high, drive local_rst_no all 0, soft_rst_ack_o all 0, done_o 0 and busy_o 1, and clear all served bits.
REQ-026 SHALL, when rst_i is asserted mid-sequence or mid-soft-reset, abandon the operation with no ack and restart from INIT_HOLD after rst_i falls.

Configuration
REQ-027 SHALL compile soft-reset support only when HEMAIA_RESET_SEQ_SOFT_RST_EN is defined.
REQ-028 SHALL, when HEMAIA_RESET_SEQ_SOFT_RST_EN is undefined, keep all ports, ignore soft_rst_req_i, tie soft_rst_ack_o to 0, omit SOFT_HOLD and SOFT_GAP, and stay in RUN permanently.

Structure
REQ-029 SHALL place the FSM state enum and timer-width function in package hemaia_reset_seq_pkg.
REQ-030 SHALL implement the hold/gap timer as sub-module hemaia_reset_seq_timer (load value, decrement, zero flag).

Verification (NumReset=4, HoldCycles=8, GapCycles=2, macro defined unless stated)
REQ-031 SHALL check boot: rst_i falls at cycle 0 -> local_rst_no bits 0..3 rise at cycles 8, 10, 12 and 14; done_o rises at cycle 16; busy_o falls at cycle 16.
REQ-032 SHALL check a single soft reset: soft_rst_req_i=4'b0100 in RUN -> local_rst_no[2] is low for 8 cycles; ack[2] pulses 2 cycles after release; the other channels never change.
REQ-033 SHALL check simultaneous requests: soft_rst_req_i=4'b1010 held -> channel 1 is served, then channel 3, with acks in that order; neither channel is re-served until its req drops.
REQ-034 SHALL check reset mid-operation: rst_i pulses during SOFT_HOLD -> all outputs go to reset values, no ack is issued, and the boot timing of REQ-031 repeats.
REQ-035 SHALL check a request during boot: soft_rst_req_i[0] rises at cycle 3 -> it is served only after done_o rises at cycle 16.
REQ-036 SHALL check the build without the macro: soft_rst_req_i=4'b1111 -> soft_rst_ack_o stays 0, local_rst_no stays 4'b1111 after boot, and busy_o stays 0.

Source files
------------

// File: rtl/hemaia_reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// hemaia_reset_seq_pkg
//   Shared types and helpers for the reset sequencer.
//   - seq_state_e : sequencer FSM state encoding. The soft-reset states exist
//                   only when HEMAIA_RESET_SEQ_SOFT_RST_EN is defined.
//   - timer_width : width of the hold/gap down-counter. It holds
//                   max(HoldCycles, GapCycles) without wrapping.
//   - idx_width   : width of a channel index. It also holds the value
//                   NumReset, which marks "all channels released".
// -----------------------------------------------------------------------------
package hemaia_reset_seq_pkg;

    typedef enum logic [2:0] {
        INIT_HOLD   = 3'd0,
        RELEASE_GAP = 3'd1,
`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
        SOFT_HOLD   = 3'd3,
        SOFT_GAP    = 3'd4,
`endif
        RUN         = 3'd2
    } seq_state_e;

    function automatic int unsigned timer_width(input int unsigned hold,
                                                input int unsigned gap);
        int unsigned m;
        m = (hold > gap) ? hold : gap;
        return $clog2(m + 1);
    endfunction

    function automatic int unsigned idx_width(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/hemaia_reset_sequencer_if.sv
// -----------------------------------------------------------------------------
// hemaia_reset_sequencer_if
//   Bundle of the sequencer's per-channel and status signals. Environments
//   that talk to the sequencer use it as a single connection.
//   Handshake: soft_rst_req is a level request per channel. Once the sequencer
//   picks a channel, that request is not looked at again until soft_rst_ack
//   pulses high for one cycle on that channel. After the ack, the requester
//   must drop the level for at least one cycle before a new request on that
//   channel is accepted.
//   modport master : requester side (drives soft_rst_req, observes the rest)
//   modport slave  : sequencer side
// -----------------------------------------------------------------------------
interface hemaia_reset_sequencer_if #(
    parameter int unsigned NumReset = 4
);
    logic [NumReset-1:0] soft_rst_req;
    logic [NumReset-1:0] soft_rst_ack;
    logic [NumReset-1:0] local_rst_n;
    logic                busy;
    logic                done;

    modport master (
        output soft_rst_req,
        input  soft_rst_ack,
        input  local_rst_n,
        input  busy,
        input  done
    );

    modport slave (
        input  soft_rst_req,
        output soft_rst_ack,
        output local_rst_n,
        output busy,
        output done
    );
endinterface

// File: rtl/hemaia_reset_seq_timer.sv
// -----------------------------------------------------------------------------
// hemaia_reset_seq_timer
//   Loadable down-counter for hold and gap intervals. The count stops at zero
//   and never wraps.
//   Ports:
//     clk_i, rst_i : clock, synchronous active-high reset (count <= RstVal)
//     load_i       : load load_val_i on this edge (takes priority)
//     load_val_i   : value to load
//     zero_o       : count is zero (decoded from the register)
// -----------------------------------------------------------------------------
module hemaia_reset_seq_timer #(
    parameter int unsigned Width  = 4,
    parameter int unsigned RstVal = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    output logic             zero_o
);
    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= Width'(RstVal);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/hemaia_reset_sequencer.sv
// -----------------------------------------------------------------------------
// hemaia_reset_sequencer
//   Boot-time reset sequencer with optional per-channel soft resets.
//   After rst_i falls, all local resets are held for HoldCycles cycles. The
//   channels are then released in ascending order, GapCycles apart. GapCycles
//   after the last release, done_o rises. In RUN, each channel's soft reset
//   request is served one at a time, lowest index first.
//   Optional feature macro: HEMAIA_RESET_SEQ_SOFT_RST_EN (soft-reset support).
//   Without it, soft_rst_req_i is ignored, soft_rst_ack_o is 0, and the FSM
//   stays in RUN after boot.
//   Ports:
//     clk_i          : clock
//     rst_i          : synchronous active-high reset
//     soft_rst_req_i : per-channel level soft-reset request
//     soft_rst_ack_o : per-channel one-cycle completion pulse
//     local_rst_no   : per-channel active-low local reset
//     busy_o         : high in every state but RUN
//     done_o         : boot sequence completed (sticky until rst_i)
//     dbg_state_o    : current FSM state, for observation
//   All outputs are driven from flops.
// -----------------------------------------------------------------------------
module hemaia_reset_sequencer
    import hemaia_reset_seq_pkg::*;
#(
    parameter int unsigned NumReset   = 4,
    parameter int unsigned HoldCycles = 8,
    parameter int unsigned GapCycles  = 2
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NumReset-1:0] soft_rst_req_i,
    output logic [NumReset-1:0] soft_rst_ack_o,
    output logic [NumReset-1:0] local_rst_no,
    output logic                busy_o,
    output logic                done_o,
    output seq_state_e          dbg_state_o
);
    localparam int unsigned TimerW = timer_width(HoldCycles, GapCycles);
    localparam int unsigned IdxW   = idx_width(NumReset);

    // Intervals loaded on a state change count the edge that follows the
    // load, so they load N-1. The reset value (HoldCycles) also counts the
    // first edge with rst_i low.
    localparam logic [TimerW-1:0] HoldLoad = TimerW'(HoldCycles - 1);
    localparam logic [TimerW-1:0] GapLoad  = TimerW'(GapCycles - 1);

    seq_state_e          state_q, state_d;
    logic [NumReset-1:0] local_rst_n_q, local_rst_n_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    // Next channel to release during boot; channel being served afterwards.
    logic [IdxW-1:0]     ch_idx_q, ch_idx_d;

    logic                timer_load;
    logic [TimerW-1:0]   timer_val;
    logic                timer_zero;

`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
    logic [NumReset-1:0] ack_q, ack_d;
    // A served channel stays blocked until its request is sampled low.
    logic [NumReset-1:0] served_q, served_d;
    logic [NumReset-1:0] eligible;
    logic [IdxW-1:0]     sel_idx;
    logic                any_eligible;

    assign eligible = soft_rst_req_i & ~served_q;

    // Lowest-index eligible channel: scanning downwards leaves the lowest set
    // bit as the final assignment.
    always_comb begin
        sel_idx      = '0;
        any_eligible = 1'b0;
        for (int i = NumReset - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_idx      = IdxW'(i);
                any_eligible = 1'b1;
            end
        end
    end
`else
    logic unused_soft_req;
    assign unused_soft_req = ^soft_rst_req_i;
`endif

    always_comb begin
        state_d       = state_q;
        local_rst_n_d = local_rst_n_q;
        done_d        = done_q;
        ch_idx_d      = ch_idx_q;
        timer_load    = 1'b0;
        timer_val     = GapLoad;
`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
        ack_d         = '0;
        served_d      = served_q & soft_rst_req_i;
`endif

        case (state_q)
            INIT_HOLD: begin
                if (timer_zero) begin
                    local_rst_n_d[0] = 1'b1;
                    ch_idx_d         = IdxW'(1);
                    timer_load       = 1'b1;
                    timer_val        = GapLoad;
                    state_d          = RELEASE_GAP;
                end
            end

            RELEASE_GAP: begin
                if (timer_zero) begin
                    if (ch_idx_q == IdxW'(NumReset)) begin
                        // Final gap after the last release has elapsed.
                        done_d  = 1'b1;
                        state_d = RUN;
                    end else begin
                        for (int i = 0; i < NumReset; i++) begin
                            if (ch_idx_q == IdxW'(i)) begin
                                local_rst_n_d[i] = 1'b1;
                            end
                        end
                        ch_idx_d   = ch_idx_q + IdxW'(1);
                        timer_load = 1'b1;
                        timer_val  = GapLoad;
                    end
                end
            end

            RUN: begin
`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
                if (any_eligible) begin
                    ch_idx_d = sel_idx;
                    for (int i = 0; i < NumReset; i++) begin
                        if (sel_idx == IdxW'(i)) begin
                            local_rst_n_d[i] = 1'b0;
                        end
                    end
                    timer_load = 1'b1;
                    timer_val  = HoldLoad;
                    state_d    = SOFT_HOLD;
                end
`endif
            end

`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
            // The served channel's request is not looked at here, so a
            // dropped request cannot abort the sequence.
            SOFT_HOLD: begin
                if (timer_zero) begin
                    for (int i = 0; i < NumReset; i++) begin
                        if (ch_idx_q == IdxW'(i)) begin
                            local_rst_n_d[i] = 1'b1;
                        end
                    end
                    timer_load = 1'b1;
                    timer_val  = GapLoad;
                    state_d    = SOFT_GAP;
                end
            end

            SOFT_GAP: begin
                if (timer_zero) begin
                    for (int i = 0; i < NumReset; i++) begin
                        if (ch_idx_q == IdxW'(i)) begin
                            ack_d[i]    = 1'b1;
                            served_d[i] = 1'b1;
                        end
                    end
                    state_d = RUN;
                end
            end
`endif

            default: begin
                state_d = INIT_HOLD;
            end
        endcase

        busy_d = (state_d != RUN);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= INIT_HOLD;
            local_rst_n_q <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b1;
            ch_idx_q      <= '0;
`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
            ack_q         <= '0;
            served_q      <= '0;
`endif
        end else begin
            state_q       <= state_d;
            local_rst_n_q <= local_rst_n_d;
            done_q        <= done_d;
            busy_q        <= busy_d;
            ch_idx_q      <= ch_idx_d;
`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
            ack_q         <= ack_d;
            served_q      <= served_d;
`endif
        end
    end

    hemaia_reset_seq_timer #(
        .Width (TimerW),
        .RstVal(HoldCycles)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (timer_load),
        .load_val_i(timer_val),
        .zero_o    (timer_zero)
    );

`ifdef HEMAIA_RESET_SEQ_SOFT_RST_EN
    assign soft_rst_ack_o = ack_q;
`else
    assign soft_rst_ack_o = '0;
`endif
    assign local_rst_no = local_rst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign dbg_state_o  = state_q;
endmodule
